// File: rtl/ysyx_23060184_rf_wb_sched_if.sv
// ysyx_23060184_rf_wb_sched_if
// Bundles the issue handshake, the two write-back handshakes, the register
// file write port and the scoreboard status of the write-back scheduler.
//   slave  : scheduler side (drives iss_ready, wbX_ready, rf_*, busy_vec, pend_cnt)
//   master : decode / requester / register-file side (drives iss_*, wbX_valid/addr/data)
interface ysyx_23060184_rf_wb_sched_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_PEND   = 4
);
    localparam int unsigned NREG  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

    // issue
    logic                  iss_valid;
    logic                  iss_ready;
    logic [ADDR_WIDTH-1:0] iss_rs1;
    logic [ADDR_WIDTH-1:0] iss_rs2;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic                  iss_wen;
    // ALU write-back
    logic                  wb0_valid;
    logic                  wb0_ready;
    logic [ADDR_WIDTH-1:0] wb0_addr;
    logic [DATA_WIDTH-1:0] wb0_data;
    // LSU write-back
    logic                  wb1_valid;
    logic                  wb1_ready;
    logic [ADDR_WIDTH-1:0] wb1_addr;
    logic [DATA_WIDTH-1:0] wb1_data;
    // register-file write port and status
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [NREG-1:0]       busy_vec;
    logic [CNT_W-1:0]      pend_cnt;

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        output iss_ready, wb0_ready, wb1_ready,
        output rf_wen, rf_waddr, rf_wdata, busy_vec, pend_cnt
    );

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        input  iss_ready, wb0_ready, wb1_ready,
        input  rf_wen, rf_waddr, rf_wdata, busy_vec, pend_cnt
    );
endinterface

// File: rtl/ysyx_23060184_rf_wb_sched.sv
// ysyx_23060184_rf_wb_sched
// Write-back scheduler and hazard scoreboard for the NPC register file.
// Tracks in-flight register writes, stalls issue on RAW/WAW hazards or when
// MAX_PEND writes are outstanding, arbitrates the single register-file write
// port round-robin between the ALU (wb0) and LSU (wb1) and drives a
// registered write strobe/address/data.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : slave modport carrying issue, write-back, rf write and status signals
module ysyx_23060184_rf_wb_sched #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_PEND   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    ysyx_23060184_rf_wb_sched_if.slave     bus
);
    localparam int unsigned NREG  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

    typedef enum logic {
        GNT_WB0 = 1'b0,
        GNT_WB1 = 1'b1
    } gnt_e;

    gnt_e                  last_gnt, last_gnt_next;
    logic [NREG-1:0]       busy, busy_next;
    logic [CNT_W-1:0]      pend, pend_next;
    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    logic                  iss_ready;
    logic                  gnt0, gnt1;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  issue_set;
    logic                  retire;

    // Issue gating: operands and destination must be free and a slot available.
    always_comb begin
        iss_ready = ~busy[bus.iss_rs1] & ~busy[bus.iss_rs2]
                  & (~bus.iss_wen | ~busy[bus.iss_rd])
                  & (pend < CNT_W'(MAX_PEND));
    end

    // Arbiter output: grant is a pure function of the valids and last_gnt.
    always_comb begin
        gnt0 = bus.wb0_valid & (~bus.wb1_valid | (last_gnt == GNT_WB1));
        gnt1 = bus.wb1_valid & (~bus.wb0_valid | (last_gnt == GNT_WB0));
    end

    // Arbiter next state: only a fired grant moves the round-robin pointer.
    always_comb begin
        last_gnt_next = last_gnt;
        if (gnt0) begin
            last_gnt_next = GNT_WB0;
        end else if (gnt1) begin
            last_gnt_next = GNT_WB1;
        end
    end

    always_comb begin
        wr_fire   = gnt0 | gnt1;
        wr_addr   = gnt0 ? bus.wb0_addr : bus.wb1_addr;
        wr_data   = gnt0 ? bus.wb0_data : bus.wb1_data;
        issue_set = bus.iss_valid & iss_ready & bus.iss_wen & (bus.iss_rd != '0);
        // A write-back to a register that is not busy is still committed but
        // does not retire anything.
        retire    = rf_wen_q & busy[rf_waddr_q];
    end

    // Set and clear never hit the same bit in one cycle: issue needs the bit
    // clear, retire needs it set.
    always_comb begin
        busy_next = busy;
        if (issue_set) begin
            busy_next[bus.iss_rd] = 1'b1;
        end
        if (retire) begin
            busy_next[rf_waddr_q] = 1'b0;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        pend_next = pend;
        case ({issue_set, retire})
            2'b10:   pend_next = pend + CNT_W'(1);
            2'b01:   pend_next = pend - CNT_W'(1);
            default: pend_next = pend;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt   <= GNT_WB1;
            busy       <= '0;
            pend       <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            last_gnt <= last_gnt_next;
            busy     <= busy_next;
            pend     <= pend_next;
            // Writes to x0 are accepted on the handshake but never strobed.
            rf_wen_q <= wr_fire & (wr_addr != '0);
            if (wr_fire) begin
                rf_waddr_q <= wr_addr;
                rf_wdata_q <= wr_data;
            end
        end
    end

    always_comb begin
        bus.iss_ready = iss_ready;
        bus.wb0_ready = gnt0;
        bus.wb1_ready = gnt1;
        bus.rf_wen    = rf_wen_q;
        bus.rf_waddr  = rf_waddr_q;
        bus.rf_wdata  = rf_wdata_q;
        bus.busy_vec  = busy;
        bus.pend_cnt  = pend;
    end
endmodule

// File: tb/tb_ysyx_23060184_rf_wb_sched.sv
// tb_ysyx_23060184_rf_wb_sched
// Self-checking bench for the write-back scheduler: a table of combinational
// ready probes, hand-written multi-cycle sequences, and a scoreboard of
// expected register-file writes checked whenever rf_wen is seen.
module tb_ysyx_23060184_rf_wb_sched;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned MP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ysyx_23060184_rf_wb_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PEND(MP)) bus ();

    ysyx_23060184_rf_wb_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PEND(MP)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wen;
        logic       v0;
        logic       v1;
        logic       exp_iss;
        logic       exp_r0;
        logic       exp_r1;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Outputs are sampled 2 ns after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0;
        bus.iss_rd = '0; bus.iss_wen = 1'b0;
        bus.wb0_valid = 1'b0; bus.wb0_addr = '0; bus.wb0_data = '0;
        bus.wb1_valid = 1'b0; bus.wb1_addr = '0; bus.wb1_data = '0;
    endtask

    task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wen);
        bus.iss_valid = v; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2;
        bus.iss_rd = rd; bus.iss_wen = wen;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard: every rf write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.rf_wen === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rf_unexpected: got write x%0d=0x%0h, required no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                e = sb.pop_front();
                chk("sb_waddr", 32'(bus.rf_waddr), 32'(e.a));
                chk("sb_wdata", bus.rf_wdata, e.d);
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] a0[3];
        logic [4:0] a1[2];
        int         g_exp[5];
        int         i0;
        int         i1;

        // Probes applied with x5 busy, pend_cnt=1, and the arbiter fresh from reset.
        vecs[0] = '{5'd5,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{5'd0,  5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{5'd0,  5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{5'd0,  5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{5'd1,  5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'd0,  5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{5'd31, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{5'd5,  5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        apply_reset();
        chk("rst_busy", bus.busy_vec, 32'h0);
        chk("rst_pend", 32'(bus.pend_cnt), 32'd0);
        chk("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'h0);

        // --- issue x5, probe hazards, write it back ---
        set_iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        #1 chk("t1_iss_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        idle();
        chk("t1_busy", bus.busy_vec, 32'h20);
        chk("t1_pend", 32'(bus.pend_cnt), 32'd1);

        for (int i = 0; i < 8; i++) begin
            set_iss(1'b0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen);
            bus.wb0_valid = vecs[i].v0;
            bus.wb1_valid = vecs[i].v1;
            #1;
            chk($sformatf("vec%0d_iss_ready", i), 32'(bus.iss_ready), 32'(vecs[i].exp_iss));
            chk($sformatf("vec%0d_wb0_ready", i), 32'(bus.wb0_ready), 32'(vecs[i].exp_r0));
            chk($sformatf("vec%0d_wb1_ready", i), 32'(bus.wb1_ready), 32'(vecs[i].exp_r1));
            idle();
            tick();
        end
        chk("vec_busy_hold", bus.busy_vec, 32'h20);
        chk("vec_pend_hold", 32'(bus.pend_cnt), 32'd1);

        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd5; bus.wb0_data = 32'hDEADBEEF;
        #1 chk("t1_wb0_ready", 32'(bus.wb0_ready), 32'd1);
        sb.push_back('{5'd5, 32'hDEADBEEF});
        tick();
        idle();
        set_iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        #1 chk("t1_dep_stall", 32'(bus.iss_ready), 32'd0);
        chk("t1_rf_wen", 32'(bus.rf_wen), 32'd1);
        chk("t1_rf_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("t1_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
        tick();
        #1 chk("t1_dep_issue", 32'(bus.iss_ready), 32'd1);
        tick();
        idle();
        chk("t1_busy_clr", bus.busy_vec, 32'h0);
        chk("t1_pend_clr", 32'(bus.pend_cnt), 32'd0);

        // --- contention: wb0 first after reset, then strict alternation ---
        apply_reset();
        set_iss(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        set_iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        idle();
        chk("t2_busy", bus.busy_vec, 32'h88);
        chk("t2_pend", 32'(bus.pend_cnt), 32'd2);
        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd3; bus.wb0_data = 32'h33;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd7; bus.wb1_data = 32'h77;
        #1;
        chk("t2_c0_wb0_ready", 32'(bus.wb0_ready), 32'd1);
        chk("t2_c0_wb1_ready", 32'(bus.wb1_ready), 32'd0);
        sb.push_back('{5'd3, 32'h33});
        tick();
        bus.wb0_valid = 1'b0;
        #1;
        chk("t2_c1_wb0_ready", 32'(bus.wb0_ready), 32'd0);
        chk("t2_c1_wb1_ready", 32'(bus.wb1_ready), 32'd1);
        sb.push_back('{5'd7, 32'h77});
        tick();
        idle();
        tick();
        chk("t2_busy_clr", bus.busy_vec, 32'h0);
        chk("t2_pend_clr", 32'(bus.pend_cnt), 32'd0);

        for (int r = 10; r <= 13; r++) begin
            set_iss(1'b1, 5'd0, 5'd0, 5'(r), 1'b1);
            tick();
        end
        idle();
        chk("t2_busy4", bus.busy_vec, 32'h3C00);
        chk("t2_pend4", 32'(bus.pend_cnt), 32'd4);

        a0[0] = 5'd10; a0[1] = 5'd12; a0[2] = 5'd0;
        a1[0] = 5'd11; a1[1] = 5'd13;
        g_exp[0] = 0; g_exp[1] = 1; g_exp[2] = 0; g_exp[3] = 1; g_exp[4] = 0;
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 5; c++) begin
            bus.wb0_valid = (i0 < 3);
            bus.wb0_addr  = (i0 < 3) ? a0[i0] : 5'd0;
            bus.wb0_data  = 32'h1000 + 32'(bus.wb0_addr);
            bus.wb1_valid = (i1 < 2);
            bus.wb1_addr  = (i1 < 2) ? a1[i1] : 5'd0;
            bus.wb1_data  = 32'h2000 + 32'(bus.wb1_addr);
            #1;
            chk($sformatf("alt%0d_wb0_ready", c), 32'(bus.wb0_ready), (g_exp[c] == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d_wb1_ready", c), 32'(bus.wb1_ready), (g_exp[c] == 1) ? 32'd1 : 32'd0);
            if (g_exp[c] == 0) begin
                if (a0[i0] != 5'd0) sb.push_back('{a0[i0], 32'h1000 + 32'(a0[i0])});
                i0++;
            end else begin
                sb.push_back('{a1[i1], 32'h2000 + 32'(a1[i1])});
                i1++;
            end
            tick();
        end
        idle();
        chk("alt_x0_rf_wen", 32'(bus.rf_wen), 32'd0);
        tick();
        chk("alt_busy_clr", bus.busy_vec, 32'h0);
        chk("alt_pend_clr", 32'(bus.pend_cnt), 32'd0);

        // --- x0 destination and x0 write-back ---
        set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        #1 chk("t3_iss_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        idle();
        chk("t3_busy", bus.busy_vec, 32'h0);
        chk("t3_pend", 32'(bus.pend_cnt), 32'd0);
        bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd0; bus.wb1_data = 32'h55;
        #1 chk("t3_wb1_ready", 32'(bus.wb1_ready), 32'd1);
        tick();
        idle();
        chk("t3_rf_wen", 32'(bus.rf_wen), 32'd0);

        // --- full at MAX_PEND, recovery after a retire ---
        for (int r = 1; r <= 4; r++) begin
            set_iss(1'b1, 5'd0, 5'd0, 5'(r), 1'b1);
            tick();
        end
        idle();
        chk("t4_pend", 32'(bus.pend_cnt), 32'd4);
        chk("t4_busy", bus.busy_vec, 32'h1E);
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 chk("t4_full_nowen", 32'(bus.iss_ready), 32'd0);
        set_iss(1'b0, 5'd0, 5'd0, 5'd9, 1'b1);
        #1 chk("t4_full_wen", 32'(bus.iss_ready), 32'd0);
        idle();
        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd2; bus.wb0_data = 32'h22;
        #1 chk("t4_wb0_ready", 32'(bus.wb0_ready), 32'd1);
        sb.push_back('{5'd2, 32'h22});
        tick();
        idle();
        #1 chk("t4_still_full", 32'(bus.iss_ready), 32'd0);
        tick();
        #1 chk("t4_recover", 32'(bus.iss_ready), 32'd1);
        chk("t4_pend3", 32'(bus.pend_cnt), 32'd3);
        chk("t4_busy3", bus.busy_vec, 32'h1A);

        // --- issue and retire in the same cycle ---
        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd1; bus.wb0_data = 32'h11;
        #1 chk("t5_wb0_ready", 32'(bus.wb0_ready), 32'd1);
        sb.push_back('{5'd1, 32'h11});
        tick();
        idle();
        set_iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        #1 chk("t5_iss_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        idle();
        chk("t5_pend", 32'(bus.pend_cnt), 32'd3);
        chk("t5_busy", bus.busy_vec, 32'h218);

        // --- reset with writes pending, an rf_wen live and wb1 requesting ---
        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd4; bus.wb0_data = 32'h44;
        #1 chk("t6_wb0_ready", 32'(bus.wb0_ready), 32'd1);
        sb.push_back('{5'd4, 32'h44});
        tick();
        idle();
        reset = 1'b1;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd3; bus.wb1_data = 32'h99;
        tick();
        reset = 1'b0;
        idle();
        chk("t6_busy", bus.busy_vec, 32'h0);
        chk("t6_pend", 32'(bus.pend_cnt), 32'd0);
        chk("t6_rf_wen", 32'(bus.rf_wen), 32'd0);
        bus.wb0_valid = 1'b1;
        bus.wb1_valid = 1'b1;
        #1;
        chk("t6_wb0_ready", 32'(bus.wb0_ready), 32'd1);
        chk("t6_wb1_ready", 32'(bus.wb1_ready), 32'd0);
        idle();
        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
